// File: rtl/adc_sample_scheduler.sv
// Arbitrates conversion requests onto the shared A/B serial converter pair,
// sequences each conversion frame and returns the four captured samples.
module adc_sample_scheduler #(
    parameter int NREQ        = 3,
    parameter int CONV_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic            abort,
    output logic            busy,
    output logic            ad_cs,
    input  logic [1:0]      ad_sdata_a,
    input  logic [1:0]      ad_sdata_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [1:0]      res_id,
    output logic [11:0]     vout,
    output logic [11:0]     iout,
    output logic [11:0]     vcap,
    output logic [11:0]     icap,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_STALL = 2'd2
    } state_e;

    localparam logic [4:0] K_LAST      = 5'(CONV_CYCLES - 1);
    localparam logic [4:0] K_FIRST_BIT = 5'd2;
    localparam logic [4:0] K_LAST_BIT  = 5'd13;

    state_e          state_q, state_d;
    logic [4:0]      k_q, k_d;
    logic [1:0]      ptr_q;
    logic [1:0]      id_q;
    logic [NREQ-1:0] gnt_q;
    logic [11:0]     sh_vout_q, sh_iout_q, sh_vcap_q, sh_icap_q;
    logic            res_valid_q;
    logic [1:0]      res_id_q;
    logic [11:0]     res_vout_q, res_iout_q, res_vcap_q, res_icap_q;

    logic            free;
    logic            arb_en;
    logic            copy;
    logic            start;
    logic            capture;
    logic            pick_valid;
    logic [1:0]      pick_idx;

    // Result port: a result transfers on any clock where res_valid && res_ready;
    // res_valid and the data hold unchanged until that happens.
    assign free = !res_valid_q || res_ready;

    // req[0] always wins; otherwise the first low-priority requester above ptr_q,
    // falling back to the lowest one when nothing sits above the pointer.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        if (req[0]) begin
            pick_valid = 1'b1;
        end else begin
            for (int j = NREQ - 1; j >= 1; j--) begin
                if (req[j] && (j > int'(ptr_q))) begin
                    pick_valid = 1'b1;
                    pick_idx   = 2'(j);
                end
            end
            if (!pick_valid) begin
                for (int j = NREQ - 1; j >= 1; j--) begin
                    if (req[j]) begin
                        pick_valid = 1'b1;
                        pick_idx   = 2'(j);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        arb_en  = 1'b0;
        copy    = 1'b0;
        case (state_q)
            S_IDLE: arb_en = 1'b1;
            S_CONV: begin
                k_d = k_q + 5'd1;
                if (k_q == K_LAST) begin
                    if (free) begin
                        copy    = 1'b1;
                        arb_en  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (free) begin
                    copy    = 1'b1;
                    arb_en  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start = arb_en && pick_valid;
        if (start) begin
            state_d = S_CONV;
            k_d     = '0;
        end
        // Abort discards the frame but leaves an already-published result alone.
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            copy    = 1'b0;
            start   = 1'b0;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        ad_cs       = (state_q == S_CONV) && (k_q == 5'd0);
        capture     = (state_q == S_CONV) && (k_q >= K_FIRST_BIT) && (k_q <= K_LAST_BIT);
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            ptr_q       <= 2'(NREQ - 1);
            id_q        <= '0;
            sh_vout_q   <= '0;
            sh_iout_q   <= '0;
            sh_vcap_q   <= '0;
            sh_icap_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_vout_q  <= '0;
            res_iout_q  <= '0;
            res_vcap_q  <= '0;
            res_icap_q  <= '0;
        end else begin
            gnt_q <= start ? (NREQ'(1) << pick_idx) : '0;
            if (start) begin
                id_q <= pick_idx;
                if (pick_idx != 2'd0) begin
                    ptr_q <= pick_idx;
                end
            end
            if (capture) begin
                sh_vout_q <= {sh_vout_q[10:0], ad_sdata_a[1]};
                sh_iout_q <= {sh_iout_q[10:0], ad_sdata_a[0]};
                sh_vcap_q <= {sh_vcap_q[10:0], ad_sdata_b[1]};
                sh_icap_q <= {sh_icap_q[10:0], ad_sdata_b[0]};
            end
            // A copy in the acceptance cycle replaces the result without a gap.
            if (copy) begin
                res_valid_q <= 1'b1;
                res_id_q    <= id_q;
                res_vout_q  <= sh_vout_q;
                res_iout_q  <= sh_iout_q;
                res_vcap_q  <= sh_vcap_q;
                res_icap_q  <= sh_icap_q;
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign vout      = res_vout_q;
    assign iout      = res_iout_q;
    assign vcap      = res_vcap_q;
    assign icap      = res_icap_q;

endmodule
